// File: rtl/instruction_fetch_unit.sv
// Instruction fetch stage: byte-addressed PC stepping by 4 each cycle,
// and a 64-word built-in program ROM read combinationally at the current PC.
module instruction_fetch_unit (
  input  logic        CLOCK,
  input  logic        RESET,
  output logic [31:0] OUTPUT
);

  localparam int unsigned PC_W   = 32;
  localparam int unsigned INSN_W = 32;
  localparam int unsigned ROM_AW = 6;

  localparam logic [INSN_W-1:0] INSN_NOP = INSN_W'(32'h0000_0013);

  logic [PC_W-1:0]   pc;
  logic [ROM_AW-1:0] rom_idx;

  // Program counter; reset takes effect immediately, independent of the clock
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      pc <= '0;
    end else begin
      pc <= pc + PC_W'(4);
    end
  end

  // Only PC[7:2] selects a word, so the image repeats every 256 bytes
  assign rom_idx = pc[7:2];

  always_comb begin
    OUTPUT = INSN_NOP;
    case (rom_idx)
      ROM_AW'(0): OUTPUT = INSN_W'(32'h0020_81B3); // add x3,x1,x2
      ROM_AW'(1): OUTPUT = INSN_W'(32'h4020_8233); // sub x4,x1,x2
      ROM_AW'(2): OUTPUT = INSN_W'(32'h0020_F2B3); // and x5,x1,x2
      ROM_AW'(3): OUTPUT = INSN_W'(32'h0020_E333); // or  x6,x1,x2
      ROM_AW'(4): OUTPUT = INSN_W'(32'h0020_C3B3); // xor x7,x1,x2
      ROM_AW'(5): OUTPUT = INSN_W'(32'h0020_9433); // sll x8,x1,x2
      ROM_AW'(6): OUTPUT = INSN_W'(32'h0020_D4B3); // srl x9,x1,x2
      ROM_AW'(7): OUTPUT = INSN_W'(32'h0020_A533); // slt x10,x1,x2
      default:    OUTPUT = INSN_NOP;
    endcase
  end

  // Byte-offset and high PC bits do not take part in the fetch
  logic unused_pc_bits;
  assign unused_pc_bits = &{1'b0, pc[PC_W-1:8], pc[1:0]};

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit: a reference PC model pushes the
// expected instruction into a scoreboard on each stimulus step; samples pop and compare.
module tb_instruction_fetch_unit;

  logic        CLOCK;
  logic        RESET;
  logic [31:0] OUTPUT;

  int tests_run = 0;
  int tests_failed = 0;

  logic [31:0] sb_q[$];
  logic [31:0] model_pc;

  instruction_fetch_unit dut (
    .CLOCK  (CLOCK),
    .RESET  (RESET),
    .OUTPUT (OUTPUT)
  );

  // 40 ns period, rising edge at 0 ns
  initial begin
    CLOCK = 1'b0;
    #0 CLOCK = 1'b1;
    forever #20 CLOCK = ~CLOCK;
  end

  function automatic logic [31:0] ref_insn(input logic [31:0] pc);
    logic [5:0] idx;
    idx = pc[7:2];
    case (idx)
      6'd0:    return 32'h002081B3;
      6'd1:    return 32'h40208233;
      6'd2:    return 32'h0020F2B3;
      6'd3:    return 32'h0020E333;
      6'd4:    return 32'h0020C3B3;
      6'd5:    return 32'h00209433;
      6'd6:    return 32'h0020D4B3;
      6'd7:    return 32'h0020A533;
      default: return 32'h00000013;
    endcase
  endfunction

  task automatic push_expected();
    sb_q.push_back(ref_insn(model_pc));
  endtask

  task automatic check_out(input string tag);
    logic [31:0] exp;
    tests_run++;
    if (sb_q.size() == 0) begin
      tests_failed++;
      $display("FAIL %s: scoreboard empty, observed %h", tag, OUTPUT);
    end else begin
      exp = sb_q.pop_front();
      assert (OUTPUT === exp) else begin
        tests_failed++;
        $error("FAIL %s: observed %h expected %h", tag, OUTPUT, exp);
      end
    end
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One rising edge with reset low: model advances, expectation queued, sampled 1 ns later
  task automatic run_edge(input string tag);
    @(posedge CLOCK);
    model_pc = model_pc + 32'd4;
    push_expected();
    #1;
    check_out(tag);
  endtask

  initial begin
    RESET    = 1'b0;
    model_pc = '0;

    // 20 ns: reset asserted between rising edges, output must follow at once
    #20;
    RESET = 1'b1;
    model_pc = '0;
    push_expected();
    #1;
    check_out("async_reset_assert");
    check_val("async_reset_const", OUTPUT, 32'h002081B3);

    // Rising edges at 40..200 ns are ignored while reset is high
    for (int i = 0; i < 5; i++) begin
      @(posedge CLOCK);
      push_expected();
      #1;
      check_out($sformatf("reset_hold_%0d", i));
      check_val($sformatf("reset_hold_pc_%0d", i), dut.pc, 32'h0);
    end

    // Release at 220 ns; edges at 240 and 280 ns
    #19;
    RESET = 1'b0;
    run_edge("edge_240");
    check_val("edge_240_const", OUTPUT, 32'h40208233);
    run_edge("edge_280");
    check_val("edge_280_const", OUTPUT, 32'h0020F2B3);

    // Reassert at 320 ns
    #39;
    RESET = 1'b1;
    model_pc = '0;
    push_expected();
    #1;
    check_out("reset_320");

    // Release between edges, then the 8-step program sequence and on to 64 edges
    #9;
    RESET = 1'b0;
    for (int i = 1; i <= 64; i++) begin
      run_edge($sformatf("seq_%0d", i));
      if (i == 8) check_val("seq_8_nop", OUTPUT, 32'h00000013);
      if (i == 63) check_val("pc_fc_word63", dut.pc, 32'h000000FC);
    end
    check_val("wrap_pc_100", dut.pc, 32'h00000100);
    check_val("wrap_out", OUTPUT, 32'h002081B3);

    // Advance to word 5 (PC=0x114), then reset mid-cycle
    for (int i = 1; i <= 5; i++) run_edge($sformatf("pre_mid_%0d", i));
    check_val("mid_pc_low_bits", dut.pc[7:0], 8'h14);
    #7;
    RESET = 1'b1;
    model_pc = '0;
    push_expected();
    #1;
    check_out("mid_reset");
    #4;
    RESET = 1'b0;
    run_edge("after_mid_release");
    check_val("after_mid_const", OUTPUT, 32'h40208233);

    if (sb_q.size() != 0) begin
      tests_run++;
      tests_failed++;
      $display("FAIL scoreboard_drain: %0d left, required 0", sb_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
# instruction_fetch_unit

Instruction fetch stage of the single-cycle RISC-V CPU. The block holds the program counter (PC) and a read-only instruction memory with a fixed built-in program. Every clock it advances the PC by 4 and presents the 32-bit instruction word at the current PC to the decode stage.

## Interface
- Parameters: none. Memory depth and program contents are fixed by this spec.
- CLOCK  input  1  system clock; all state changes on its rising edge.
- RESET  input  1  asynchronous, active-high reset.
- OUTPUT  output  32  instruction code at the current PC.

## Operation
- PC: 32-bit internal register, byte address.
  - While RESET=1: PC=0x00000000.
  - Otherwise, on each rising edge of CLOCK: PC <= PC + 4, modulo 2^32.
- Instruction memory: 64 x 32-bit ROM, word-addressed by PC[7:2]. PC[1:0] and PC[31:8] are ignored, so the program image repeats every 256 bytes.
- ROM contents, as word index: value (instruction):
  - 0: 0x002081B3 (add x3,x1,x2)
  - 1: 0x40208233 (sub x4,x1,x2)
  - 2: 0x0020F2B3 (and x5,x1,x2)
  - 3: 0x0020E333 (or x6,x1,x2)
  - 4: 0x0020C3B3 (xor x7,x1,x2)
  - 5: 0x00209433 (sll x8,x1,x2)
  - 6: 0x0020D4B3 (srl x9,x1,x2)
  - 7: 0x0020A533 (slt x10,x1,x2)
  - 8..63: 0x00000013 (nop)
- OUTPUT = ROM[PC[7:2]]. This is a combinational read with no output register.
- No branch or jump input. The fetch sequence is strictly sequential.

## Timing
- Reset:
  - Assertion clears PC immediately, without waiting for a clock edge.
  - Within the same delta cycle, OUTPUT = 0x002081B3.
  - While RESET=1, clock edges are ignored.
- Reset release: the first rising edge with RESET=0 sets PC=4, giving OUTPUT=0x40208233 after that edge.
- Latency: OUTPUT changes in the same cycle the PC changes (0 cycles after the PC update).
- Reset mid-operation: PC returns to 0 asynchronously, regardless of clock phase, and fetch restarts from word 0 after release.
- Before the first reset, PC and OUTPUT are undefined. The system must assert RESET before use.
- Wrap-around:
  - PC=0x000000FC fetches word 63 (0x00000013). The next edge gives PC=0x00000100, which fetches word 0 again (0x002081B3).
  - PC=0xFFFFFFFC advances to 0x00000000.

## Test plan
- Reset asserted asynchronously between clock edges -> OUTPUT=0x002081B3 before the next edge, with no clock edge needed.
- RESET held high across 5 rising edges -> OUTPUT stays 0x002081B3 and PC stays 0.
- Release reset, then apply 8 rising edges -> OUTPUT sequence 0x40208233, 0x0020F2B3, 0x0020E333, 0x0020C3B3, 0x00209433, 0x0020D4B3, 0x0020A533, 0x00000013.
- Run 64 edges from reset -> OUTPUT returns to 0x002081B3 (PC=0x100, ROM index wraps).
- Reassert RESET mid-sequence (PC=0x14) -> OUTPUT immediately 0x002081B3. After release, one edge gives 0x40208233.
- Clock period 40 ns (first edge at 0 ns is a rising edge); RESET low 0–20 ns, high 20–220 ns, low 220–320 ns, high from 320 ns.
  - During 20–220 ns, OUTPUT=0x002081B3.
  - Edge at 240 ns gives 0x40208233; edge at 280 ns gives 0x0020F2B3.
  - At 320 ns, OUTPUT returns to 0x002081B3.
